// File: rtl/ones_count_arbiter.sv
// Round-robin arbiter sharing one external 7-in/3-out ones-count datapath between two requesters.
// Optional checker compare against a second datapath is enabled by defining DUAL_CHECK_EN.
module ones_count_arbiter #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_i,
  input  logic [6:0] op0_i,
  input  logic       req1_i,
  input  logic [6:0] op1_i,
  output logic [6:0] dp_a_o,
  input  logic [2:0] dp_y_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic [2:0] res_o,
  output logic       busy_o,
  output logic       gnt_o
`ifdef DUAL_CHECK_EN
  ,
  input  logic [2:0] dp_x_i,
  output logic       err_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             sel;

  // On a tie the requester that was not served last wins; otherwise whoever is asking.
  always_comb begin
    sel = (req0_i && req1_i) ? ~last : req1_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      last   <= 1'b1;
      dp_a_o <= '0;
      res_o  <= '0;
      ack0_o <= 1'b0;
      ack1_o <= 1'b0;
      busy_o <= 1'b0;
      gnt_o  <= 1'b0;
`ifdef DUAL_CHECK_EN
      err_o  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req0_i || req1_i) begin
            dp_a_o <= sel ? op1_i : op0_i;
            gnt_o  <= sel;
            last   <= sel;
            cnt    <= CNT_W'(SETTLE_CYCLES - 1);
            busy_o <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            res_o  <= dp_y_i;
            ack0_o <= ~gnt_o;
            ack1_o <= gnt_o;
`ifdef DUAL_CHECK_EN
            if (dp_x_i != dp_y_i) err_o <= 1'b1;
`endif
            state  <= S_RESP;
          end
        end
        S_RESP: begin
          // No accept on this edge: the requester needs a cycle to see its ack.
          ack0_o <= 1'b0;
          ack1_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
